// File: rtl/dbus_arbiter.sv
// ----------------------------------------------------------------------------
// dbus_arbiter
//
// Arbitrates the shared data path (memory + io_bridge) between two data-side
// requesters: requester 0 (CPU data port) and requester 1 (DMA engine).
// One transaction is in flight at a time. The owner is picked round robin when
// both requesters ask at once. The address is decoded into the memory or I/O
// region. A single-cycle read/write strobe is issued, and read data is
// captured after the region's latency. The owner then gets a one-cycle ack.
//
// Parameters
//   IO_BASE  addresses >= IO_BASE (unsigned) belong to the I/O region
//   MEM_LAT  strobe-to-read-data cycles for memory (1..15)
//   IO_LAT   strobe-to-read-data cycles for I/O    (1..15)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0/req1                transaction requests
//   we0/we1                  1 = write, 0 = read
//   addr0/addr1              word addresses
//   wdata0/wdata1            write data
//   ack0/ack1                one-cycle completion pulse to the owner
//   rdata                    captured read data, valid in the ack cycle
//   owner                    requester that holds / last held the bus
//   busy                     transaction in progress (ACCESS or DONE)
//   d_addr, d_wdata          latched address / write data to the data path
//   mem_read, mem_write      single-cycle memory strobes
//   io_read, io_write        single-cycle I/O strobes
//   mem_rdata, io_rdata      read data returned by memory / io_bridge
// ----------------------------------------------------------------------------
module dbus_arbiter #(
    parameter logic [15:0] IO_BASE = 16'hFF00,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned IO_LAT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        owner,
    output logic        busy,
    output logic [15:0] d_addr,
    output logic [15:0] d_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic        io_read,
    output logic        io_write,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] io_rdata
);

    // Counter load values: the counter counts the remaining ACCESS cycles
    // after the current one, so LAT=1 loads zero and finishes immediately.
    localparam logic [3:0] MEM_CNT = 4'(MEM_LAT - 1);
    localparam logic [3:0] IO_CNT  = 4'(IO_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_q;
    logic        we_q;
    logic        io_q;
    logic [3:0]  cnt_q;
    logic [15:0] d_addr_q;
    logic [15:0] d_wdata_q;
    logic [15:0] rdata_q;
    logic        busy_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        io_read_q;
    logic        io_write_q;

    // Grant decode. These values are only consumed on the IDLE clock edge.
    // The req inputs never reach an output without passing through a register.
    logic        grant_valid_d;
    logic        grant_d;
    logic [15:0] sel_addr_d;
    logic [15:0] sel_wdata_d;
    logic        sel_we_d;
    logic        sel_io_d;
    logic [3:0]  cnt_load_d;
    logic [3:0]  cnt_d;

    always_comb begin
        grant_valid_d = req0 | req1;
        // When both requesters are contending, the one that did not own the
        // bus last wins. A lone requester always wins.
        if (req0 && req1) begin
            grant_d = ~owner_q;
        end else begin
            grant_d = req1;
        end
        sel_addr_d  = grant_d ? addr1  : addr0;
        sel_wdata_d = grant_d ? wdata1 : wdata0;
        sel_we_d    = grant_d ? we1    : we0;
        sel_io_d    = (sel_addr_d >= IO_BASE);
        cnt_load_d  = sel_io_d ? IO_CNT : MEM_CNT;
        cnt_d       = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b1;
            we_q        <= 1'b0;
            io_q        <= 1'b0;
            cnt_q       <= 4'd0;
            d_addr_q    <= 16'h0000;
            d_wdata_q   <= 16'h0000;
            rdata_q     <= 16'h0000;
            busy_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            io_read_q   <= 1'b0;
            io_write_q  <= 1'b0;
        end else begin
            // Strobes and acks are pulses. They default low each cycle and are
            // set only on the transition that starts the relevant cycle.
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            io_read_q   <= 1'b0;
            io_write_q  <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_d) begin
                        owner_q     <= grant_d;
                        d_addr_q    <= sel_addr_d;
                        d_wdata_q   <= sel_wdata_d;
                        we_q        <= sel_we_d;
                        io_q        <= sel_io_d;
                        cnt_q       <= cnt_load_d;
                        busy_q      <= 1'b1;
                        // Strobe is registered here so it is high in exactly
                        // the first ACCESS cycle.
                        mem_read_q  <= ~sel_io_d & ~sel_we_d;
                        mem_write_q <= ~sel_io_d &  sel_we_d;
                        io_read_q   <=  sel_io_d & ~sel_we_d;
                        io_write_q  <=  sel_io_d &  sel_we_d;
                        state_q     <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_d;
                    end else begin
                        // Last ACCESS cycle: read data is valid on this edge.
                        if (!we_q) begin
                            rdata_q <= io_q ? io_rdata : mem_rdata;
                        end
                        ack0_q  <= ~owner_q;
                        ack1_q  <=  owner_q;
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pulses are gated by reset so an aborted transaction drops its strobe or
    // ack in the reset cycle itself instead of one edge later.
    assign mem_read  = mem_read_q  & ~rst;
    assign mem_write = mem_write_q & ~rst;
    assign io_read   = io_read_q   & ~rst;
    assign io_write  = io_write_q  & ~rst;
    assign ack0      = ack0_q      & ~rst;
    assign ack1      = ack1_q      & ~rst;

    assign rdata   = rdata_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign d_addr  = d_addr_q;
    assign d_wdata = d_wdata_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dbus_arbiter
//
// Testbench for dbus_arbiter with default parameters (IO_BASE=FF00,
// MEM_LAT=1, IO_LAT=3). A directed vector table and randomized transactions
// go through one transaction driver. The memory / io_bridge data buses carry
// the expected word only in the cycle the data must be sampled, and junk in
// every other cycle. Expected owner, region, latency and read data come from
// a transaction-level model of the arbitration rules. Hand-written sequences
// cover reset state, idle behaviour and reset abort.
// ----------------------------------------------------------------------------
module tb_dbus_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata;
    logic        owner, busy;
    logic [15:0] d_addr, d_wdata;
    logic        mem_read, mem_write, io_read, io_write;
    logic [15:0] mem_rdata, io_rdata;

    dbus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .owner     (owner),
        .busy      (busy),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .io_read   (io_read),
        .io_write  (io_write),
        .mem_rdata (mem_rdata),
        .io_rdata  (io_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: requester inputs, the word the target returns, and the
    // expected grant, region, latency and rdata after the ack.
    typedef struct {
        logic        r0;
        logic        r1;
        logic        w0;
        logic        w1;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] rd;
        logic        e_owner;
        logic        e_io;
        int          e_lat;
        logic [15:0] e_rdata;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Transaction-level model state: who held the bus last and what rdata holds.
    logic        m_owner;
    logic [15:0] m_rdata;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp_v, $time);
        end
    endtask

    // Called at the falling edge of an IDLE cycle. Drives the request so that
    // the next rising edge is the grant edge (end of cycle N). Checks every
    // cycle N+1 .. N+LAT+2 and returns at the falling edge of the IDLE cycle
    // that follows the ack.
    task automatic do_txn(input vec_t v);
        logic [15:0] exp_addr;
        logic [15:0] exp_wd;
        logic        exp_we;
        logic [3:0]  exp_strb;
        logic [1:0]  exp_ack;
        req0 = v.r0;  req1 = v.r1;
        we0  = v.w0;  we1  = v.w1;
        addr0 = v.a0; addr1 = v.a1;
        wdata0 = v.d0; wdata1 = v.d1;
        exp_addr = v.e_owner ? v.a1 : v.a0;
        exp_wd   = v.e_owner ? v.d1 : v.d0;
        exp_we   = v.e_owner ? v.w1 : v.w0;
        // Strobe order: {mem_read, mem_write, io_read, io_write}
        exp_strb = v.e_io ? (exp_we ? 4'b0001 : 4'b0010)
                          : (exp_we ? 4'b0100 : 4'b1000);
        exp_ack  = v.e_owner ? 2'b10 : 2'b01;
        for (int k = 1; k <= v.e_lat + 2; k++) begin
            @(negedge clk);
            chk("strobes", 16'({mem_read, mem_write, io_read, io_write}),
                16'((k == 1) ? exp_strb : 4'b0000));
            chk("acks", 16'({ack1, ack0}), 16'((k == v.e_lat + 1) ? exp_ack : 2'b00));
            chk("busy", 16'(busy), 16'(k <= v.e_lat + 1));
            chk("owner", 16'(owner), 16'(v.e_owner));
            if (k <= v.e_lat) begin
                chk("d_addr", d_addr, exp_addr);
                chk("d_wdata", d_wdata, exp_wd);
            end
            if (k >= v.e_lat + 1) begin
                chk("rdata", rdata, v.e_rdata);
            end
            // The target returns valid data only in the last ACCESS cycle.
            mem_rdata = (k == v.e_lat && !v.e_io) ? v.rd : (16'hDEAD ^ 16'(k));
            io_rdata  = (k == v.e_lat &&  v.e_io) ? v.rd : (16'hBAD0 ^ 16'(k));
            // Disturb the requester inputs after the grant. The latched
            // transaction must not follow them.
            if (k == 1) begin
                addr0  = 16'h1234;
                addr1  = 16'h1234;
                wdata0 = ~wdata0;
                wdata1 = ~wdata1;
                we0    = ~we0;
                we1    = ~we1;
            end
        end
        m_owner = v.e_owner;
        m_rdata = v.e_rdata;
        $display("txn %0d owner=%0d io=%0d we=%0d addr=%h lat=%0d rdata=%h",
                 n_txn, v.e_owner, v.e_io, exp_we, exp_addr, v.e_lat, v.e_rdata);
        n_txn++;
    endtask

    // Reference model: derive the expected outcome from the arbitration rules.
    function automatic vec_t predict(input vec_t v);
        vec_t        r;
        logic [15:0] a;
        logic        w;
        r = v;
        r.e_owner = (v.r0 && v.r1) ? ~m_owner : v.r1;
        a = r.e_owner ? v.a1 : v.a0;
        w = r.e_owner ? v.w1 : v.w0;
        r.e_io    = (a >= 16'hFF00);
        r.e_lat   = r.e_io ? 3 : 1;
        r.e_rdata = w ? m_rdata : v.rd;
        return r;
    endfunction

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 16'hFEFF;
            1:       return 16'hFF00;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t tbl[11];
    vec_t rv;

    initial begin
        // Directed vectors, applied in order starting from reset (owner=1).
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1, 16'hBEEF};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hFF02, 16'h0000, 16'h00A5, 16'h0000, 1'b1, 1'b1, 3, 16'hBEEF};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hFF10, 16'h0000, 16'h0000, 16'h1111, 1'b0, 1'b0, 1, 16'h1111};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hFF10, 16'h0000, 16'h0000, 16'h2222, 1'b1, 1'b1, 3, 16'h2222};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hFF10, 16'h0000, 16'h0000, 16'h3131, 1'b0, 1'b0, 1, 16'h3131};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hFF10, 16'h0000, 16'h0000, 16'h4242, 1'b1, 1'b1, 3, 16'h4242};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFEFF, 16'h0000, 16'h0000, 16'h0000, 16'h3333, 1'b0, 1'b0, 1, 16'h3333};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFF00, 16'h0000, 16'h0000, 16'h4444, 1'b1, 1'b1, 3, 16'h4444};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 1'b0, 1'b1, 3, 16'h5555};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hABCD, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 1, 16'h5555};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h8000, 16'h0000, 16'h7777, 16'h0F0F, 1'b1, 1'b0, 1, 16'h5555};

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
        mem_rdata = 16'h0; io_rdata = 16'h0;
        m_owner = 1'b1;
        m_rdata = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_strobes", 16'({mem_read, mem_write, io_read, io_write}), 16'h0);
        chk("rst_acks", 16'({ack1, ack0}), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_owner", 16'(owner), 16'h1);
        chk("rst_d_addr", d_addr, 16'h0);
        chk("rst_d_wdata", d_wdata, 16'h0);
        chk("rst_rdata", rdata, 16'h0);

        for (int i = 0; i < 11; i++) begin
            do_txn(tbl[i]);
        end

        // Randomized transactions against the model
        for (int i = 0; i < 40; i++) begin
            rv.r0 = 1'($urandom_range(0, 1));
            rv.r1 = rv.r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.w0 = 1'($urandom_range(0, 1));
            rv.w1 = 1'($urandom_range(0, 1));
            rv.a0 = rand_addr();
            rv.a1 = rand_addr();
            rv.d0 = 16'($urandom);
            rv.d1 = 16'($urandom);
            rv.rd = 16'($urandom);
            do_txn(predict(rv));
        end

        // No request: the arbiter stays idle.
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy", 16'(busy), 16'h0);
            chk("idle_strobes", 16'({mem_read, mem_write, io_read, io_write}), 16'h0);
        end

        // Reset during the ACCESS cycle of an I/O read
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'hFF00; wdata0 = 16'h0;
        @(negedge clk);
        chk("abort_io_read", 16'(io_read), 16'h1);
        chk("abort_busy_pre", 16'(busy), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strobes", 16'({mem_read, mem_write, io_read, io_write}), 16'h0);
        chk("abort_acks", 16'({ack1, ack0}), 16'h0);
        chk("abort_busy", 16'(busy), 16'h0);
        chk("abort_d_addr", d_addr, 16'h0);
        chk("abort_owner", 16'(owner), 16'h1);
        rst = 1'b0;
        req0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ack", 16'({ack1, ack0}), 16'h0);
            chk("abort_idle", 16'(busy), 16'h0);
        end
        m_owner = 1'b1;
        m_rdata = 16'h0;

        // First contended request after reset goes to requester 0.
        rv = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0030, 16'h0000, 16'h0000, 16'h6060, 1'b0, 1'b0, 1, 16'h0000};
        do_txn(predict(rv));
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Data-bus arbiter and sequencer between the data-side requesters (CPU data port, DMA engine) and the shared data path to `memory` and `io_bridge`. It grants one requester at a time with round-robin fairness and decodes the address into the memory or I/O region. It generates single-cycle read/write strobes and waits a per-region latency before capturing read data. It returns a one-cycle acknowledge to the owner.

## Interface
Parameters:
- IO_BASE, 16'hFF00: addresses >= IO_BASE are I/O; all lower addresses are memory.
- MEM_LAT, 1: cycles from memory strobe to memory read data valid (legal range 1..15).
- IO_LAT, 3: cycles from I/O strobe to I/O read data valid (legal range 1..15).

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  transaction request from requester 0 (CPU) / 1 (DMA).
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  16  word address.
- wdata0 / wdata1  in  16  write data.
- ack0 / ack1  out  1  one-cycle transaction-complete pulse.
- rdata  out  16  read data; valid in the ack cycle.
- owner  out  1  requester that currently holds, or last held, the bus.
- busy  out  1  high while a transaction is in progress (ACCESS or DONE).
- d_addr  out  16  address to memory / io_bridge.
- d_wdata  out  16  write data to memory / io_bridge.
- mem_read, mem_write, io_read, io_write  out  1  single-cycle strobes.
- mem_rdata / io_rdata  in  16  read data from memory / io_bridge.

## Operation
- FSM with three states: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If only one requester has req high, grant it.
  - If both have req high, grant the requester other than `owner` (round robin).
  - On grant, latch the following, then go to ACCESS:
    - owner, addr, wdata and we of the granted requester;
    - region bit, io = (addr >= IO_BASE), compared unsigned;
    - counter = selected LAT − 1.
- ACCESS:
  - First cycle: assert exactly one strobe, selected by region and we.
  - Every cycle: drive d_addr and d_wdata from the latched values.
  - While counter != 0, decrement it.
  - When counter == 0:
    - for a read, capture mem_rdata or io_rdata (by region) into rdata;
    - go to DONE.
- DONE:
  - Pulse ack of the owner for one cycle; rdata stays stable.
  - Go to IDLE.
- On writes, rdata keeps its previous value.
- The arbiter ignores req while busy, and ignores changes to addr, wdata and we after the grant.
- Each requester holds req, we, addr and wdata stable until its ack. It may drop req in the cycle after ack. If req is still high in the following IDLE cycle, that is a new transaction.
- The non-owner's ack stays low throughout.
- Reset values:
  - state = IDLE;
  - all strobes, ack0, ack1 and busy = 0;
  - d_addr, d_wdata and rdata = 0;
  - owner = 1, so requester 0 wins the first contended grant.
- A reset during ACCESS or DONE aborts the transaction: no ack is issued and strobes drop in the same cycle.

## Timing
- Grant cycle N is the IDLE cycle in which req is sampled.
- The strobe is high in cycle N+1 only.
- ACCESS occupies cycles N+1 .. N+LAT.
- Read data is sampled on the edge that ends cycle N+LAT.
- ack and valid rdata appear in cycle N+LAT+1.
- Memory read with MEM_LAT=1: ack at N+2. I/O access with IO_LAT=3: ack at N+4.
- There is one mandatory IDLE cycle between transactions. Back-to-back memory accesses therefore sustain one transaction every LAT+2 cycles.
- LAT=1 means ACCESS lasts one cycle: the strobe and the data sample fall in the same cycle.
- Address boundaries: IO_BASE−1 (16'hFEFF) is memory; IO_BASE (16'hFF00) and 16'hFFFF are I/O.
- No combinational path from any req input to any output; every output is registered or decoded from registered state.

## Test plan
- Reset, then req0=1, we0=0, addr0=16'h0010, with mem_rdata=16'hBEEF from the strobe cycle on:
  - mem_read high in cycle N+1 only;
  - ack0 and rdata=16'hBEEF in cycle N+2;
  - ack1 never asserts.
- req1=1, we1=1, addr1=16'hFF02, wdata1=16'h00A5:
  - io_write one cycle with d_addr=16'hFF02 and d_wdata=16'h00A5;
  - ack1 at N+4;
  - mem_write stays low.
- req0 and req1 both held high continuously after reset:
  - grants alternate 0,1,0,1 with owner toggling;
  - one IDLE cycle between transactions, each ack one cycle.
- Region edges:
  - addr 16'hFEFF asserts mem_read;
  - addr 16'hFF00 and 16'hFFFF assert io_read;
  - the ack cycle matches the respective LAT.
- Change addr0 to 16'h1234 during ACCESS: d_addr keeps the latched value.
- Assert rst in the ACCESS cycle of an I/O read:
  - next cycle all strobes, acks and busy are 0, d_addr=0, owner=1;
  - a subsequent contended request is granted to requester 0.
